// File: rtl/rle_encoder_ctrl_if.sv
// Valid/ready bundle between the bit source, the RLE controller and the symbol packer.
// slave: the controller's view. master: the view of whatever drives the stream
// and accepts the symbols.
interface rle_encoder_ctrl_if #(parameter int CNT_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic [CNT_W-1:0] out_count;
    logic             out_last;

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_bit, out_count, out_last
    );

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_bit, out_count, out_last
    );
endinterface

// File: rtl/rle_encoder_ctrl.sv
// rle_encoder_ctrl: turns a serial bit stream into (bit, run-length) symbols.
// Runs longer than 2^CNT_W-1 are split into several symbols. The bit that ends
// a run is parked in a one-entry pending slot while the finished symbol drains.
// Optional statistics counters are enabled with `define RLE_CTRL_STATS_EN.
//
// Handshake: a transfer happens on a side exactly in the cycle where both valid
// and ready are high. in_ready and out_valid depend only on the state, never on
// the opposite side's inputs. While out_valid=1 and out_ready=0, out_bit,
// out_count and out_last stay constant.
module rle_encoder_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    rle_encoder_ctrl_if.slave    bus,
    output logic                 busy,
    output logic [1:0]           dbg_state
`ifdef RLE_CTRL_STATS_EN
    ,
    output logic [15:0]          stat_symbols,
    output logic [15:0]          stat_splits
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic             cur_bit;
    logic [CNT_W-1:0] count;
    logic             pend_valid;
    logic             pend_bit;
    logic             pend_last;
    logic             last_flag;

    logic in_acc;
    logic out_acc;
    logic same_bit;
    logic split_sat;

    // Handshake and run-continuation decodes, all derived from the current state.
    always_comb begin
        bus.in_ready  = (state != EMIT);
        bus.out_valid = (state == EMIT);
        bus.out_bit   = (state == EMIT) ? cur_bit : 1'b0;
        bus.out_count = (state == EMIT) ? count : '0;
        bus.out_last  = (state == EMIT) && last_flag && !pend_valid;
        busy          = (state != IDLE);
        dbg_state     = state;
        in_acc        = bus.in_valid && bus.in_ready;
        out_acc       = bus.out_valid && bus.out_ready;
        same_bit      = (bus.in_bit == cur_bit);
        split_sat     = (state == RUN) && in_acc && same_bit && (count == MAX);
    end

    // Run tracking FSM: accumulate in RUN, present symbol in EMIT, then pick up
    // the parked bit as the first bit of the next run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_bit    <= 1'b0;
            count      <= '0;
            pend_valid <= 1'b0;
            pend_bit   <= 1'b0;
            pend_last  <= 1'b0;
            last_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_acc) begin
                        cur_bit <= bus.in_bit;
                        count   <= ONE;
                        if (bus.in_last) begin
                            last_flag <= 1'b1;
                            state     <= EMIT;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_acc) begin
                        if (same_bit && (count != MAX)) begin
                            count <= count + ONE;
                            if (bus.in_last) begin
                                last_flag <= 1'b1;
                                state     <= EMIT;
                            end
                        end else begin
                            // Bit change or saturated counter: close this run and
                            // park the accepted bit for the next one.
                            pend_valid <= 1'b1;
                            pend_bit   <= bus.in_bit;
                            pend_last  <= bus.in_last;
                            state      <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_acc) begin
                        if (pend_valid) begin
                            cur_bit    <= pend_bit;
                            count      <= ONE;
                            pend_valid <= 1'b0;
                            if (pend_last) begin
                                last_flag <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            last_flag <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RLE_CTRL_STATS_EN
    // Saturating symbol and saturation-split counters, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_symbols <= 16'h0000;
            stat_splits  <= 16'h0000;
        end else begin
            if (out_acc && (stat_symbols != 16'hFFFF)) begin
                stat_symbols <= stat_symbols + 16'h0001;
            end
            if (split_sat && (stat_splits != 16'hFFFF)) begin
                stat_splits <= stat_splits + 16'h0001;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rle_encoder_ctrl.sv
// Bench for rle_encoder_ctrl: table of per-cycle vectors for an 8-bit counter
// instance, plus hand-written sequences for async reset mid-run and counter
// saturation on a 3-bit counter instance.
module tb_rle_encoder_ctrl;
    logic clock;
    logic reset;
    logic busy8, busy3;
    logic [1:0] st8, st3;

    rle_encoder_ctrl_if #(.CNT_W(8)) bus8 ();
    rle_encoder_ctrl_if #(.CNT_W(3)) bus3 ();

`ifdef RLE_CTRL_STATS_EN
    logic [15:0] sym8, spl8, sym3, spl3;
`endif

    rle_encoder_ctrl #(.CNT_W(8)) dut8 (
        .clock(clock), .reset(reset), .bus(bus8.slave), .busy(busy8), .dbg_state(st8)
`ifdef RLE_CTRL_STATS_EN
        , .stat_symbols(sym8), .stat_splits(spl8)
`endif
    );

    rle_encoder_ctrl #(.CNT_W(3)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3.slave), .busy(busy3), .dbg_state(st3)
`ifdef RLE_CTRL_STATS_EN
        , .stat_symbols(sym3), .stat_splits(spl3)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- vector table ----------------
    // stim = {in_valid, in_bit, in_last, out_ready}
    // exp  = {in_ready, out_valid, out_bit, out_count[7:0], out_last, busy}
    typedef struct {
        int          grp;
        logic [3:0]  stim;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_miss;

    logic [4:0] exp_q[$];

    function automatic void add(input int g, input logic v, input logic b, input logic l,
                                input logic r, input logic ir, input logic ov, input logic ob,
                                input logic [7:0] oc, input logic ol, input logic bz);
        vec_t t;
        t.grp  = g;
        t.stim = {v, b, l, r};
        t.exp  = {ir, ov, ob, oc, ol, bz};
        vecs.push_back(t);
    endfunction

    function automatic logic [12:0] sample8();
        return {bus8.in_ready, bus8.out_valid, bus8.out_bit, bus8.out_count,
                bus8.out_last, busy8};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_row(input int k);
        logic [12:0] got;
        @(negedge clock);
        {bus8.in_valid, bus8.in_bit, bus8.in_last, bus8.out_ready} = vecs[k].stim;
        #1;
        got = sample8();
        n_vec++;
        if (got !== vecs[k].exp) begin
            n_miss++;
            $display("FAIL grp%0d row%0d: got {ir,ov,ob,cnt,ol,busy}=%b want %b",
                     vecs[k].grp, k, got, vecs[k].exp);
        end
    endtask

    task automatic run_group(input int g);
        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].grp == g) apply_row(k);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        {bus8.in_valid, bus8.in_bit, bus8.in_last, bus8.out_ready} = 4'b0000;
        {bus3.in_valid, bus3.in_bit, bus3.in_last, bus3.out_ready} = 4'b0001;

        // grp 1: basic frame 1,1,1,0,0(last)
        add(1, 1,1,0,1,  1,0,0,8'd0,0,0);
        add(1, 1,1,0,1,  1,0,0,8'd0,0,1);
        add(1, 1,1,0,1,  1,0,0,8'd0,0,1);
        add(1, 1,0,0,1,  1,0,0,8'd0,0,1);
        add(1, 1,0,1,1,  0,1,1,8'd3,0,1);
        add(1, 1,0,1,1,  1,0,0,8'd0,0,1);
        add(1, 0,0,0,1,  0,1,0,8'd2,1,1);
        add(1, 0,0,0,1,  1,0,0,8'd0,0,0);
        // grp 2: single-bit frame
        add(2, 1,1,1,1,  1,0,0,8'd0,0,0);
        add(2, 0,0,0,1,  0,1,1,8'd1,1,1);
        add(2, 0,0,0,1,  1,0,0,8'd0,0,0);
        // grp 3: final run of length 1: 0,0,1(last)
        add(3, 1,0,0,1,  1,0,0,8'd0,0,0);
        add(3, 1,0,0,1,  1,0,0,8'd0,0,1);
        add(3, 1,1,1,1,  1,0,0,8'd0,0,1);
        add(3, 0,0,0,1,  0,1,0,8'd2,0,1);
        add(3, 0,0,0,1,  0,1,1,8'd1,1,1);
        add(3, 0,0,0,1,  1,0,0,8'd0,0,0);
        // grp 4: backpressure on (1,3), next frame bit held at input meanwhile
        add(4, 1,1,0,0,  1,0,0,8'd0,0,0);
        add(4, 1,1,0,0,  1,0,0,8'd0,0,1);
        add(4, 1,1,0,0,  1,0,0,8'd0,0,1);
        add(4, 1,0,1,0,  1,0,0,8'd0,0,1);
        for (int i = 0; i < 5; i++) add(4, 1,1,1,0,  0,1,1,8'd3,0,1);
        add(4, 1,1,1,1,  0,1,1,8'd3,0,1);
        add(4, 1,1,1,1,  0,1,0,8'd1,1,1);
        add(4, 1,1,1,1,  1,0,0,8'd0,0,0);
        add(4, 0,0,0,1,  0,1,1,8'd1,1,1);
        add(4, 0,0,0,1,  1,0,0,8'd0,0,0);
        // grp 5: start of a run that reset will cut short
        add(5, 1,1,0,1,  1,0,0,8'd0,0,0);
        add(5, 1,1,0,1,  1,0,0,8'd0,0,1);
        add(5, 1,1,0,1,  1,0,0,8'd0,0,1);
        // grp 6: after reset, frame "0 last"
        add(6, 1,0,1,1,  1,0,0,8'd0,0,0);
        add(6, 0,0,0,1,  0,1,0,8'd1,1,1);
        add(6, 0,0,0,1,  1,0,0,8'd0,0,0);

        // Reset state
        #2;
        check_val("reset_outputs8", {3'b0, sample8()}, {3'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
        check_val("reset_state8", {14'b0, st8}, 16'd0);
        @(negedge clock);
        reset = 1'b0;

        run_group(1);
        run_group(2);
        run_group(3);
        run_group(4);

        // Reset in the middle of a run
        run_group(5);
        @(posedge clock);
        #2;
        bus8.out_ready = 1'b1;
        reset = 1'b1;
        #1;
        check_val("midrun_reset_busy", {15'b0, busy8}, 16'd0);
        check_val("midrun_reset_out_valid", {15'b0, bus8.out_valid}, 16'd0);
        check_val("midrun_reset_in_ready", {15'b0, bus8.in_ready}, 16'd1);
        check_val("midrun_reset_state", {14'b0, st8}, 16'd0);
        @(negedge clock);
        {bus8.in_valid, bus8.in_bit, bus8.in_last} = 3'b000;
        reset = 1'b0;
        run_group(6);

        // Saturation on the 3-bit instance: 16 ones, last on the final one
        exp_q.push_back({1'b1, 3'd7, 1'b0});
        exp_q.push_back({1'b1, 3'd7, 1'b0});
        exp_q.push_back({1'b1, 3'd2, 1'b1});
        begin
            int  idx;
            int  seen;
            logic [4:0] got_sym;
            logic [4:0] want_sym;
            idx  = 0;
            seen = 0;
            for (int cyc = 0; cyc < 200 && !(idx == 16 && seen == 3); cyc++) begin
                @(negedge clock);
                if (idx < 16) begin
                    bus3.in_valid = 1'b1;
                    bus3.in_bit   = 1'b1;
                    bus3.in_last  = (idx == 15);
                end else begin
                    bus3.in_valid = 1'b0;
                    bus3.in_bit   = 1'b0;
                    bus3.in_last  = 1'b0;
                end
                #1;
                if (bus3.out_valid) begin
                    got_sym = {bus3.out_bit, bus3.out_count, bus3.out_last};
                    seen++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_miss++;
                        $display("FAIL sat_extra_symbol: got %b want none", got_sym);
                    end else begin
                        want_sym = exp_q.pop_front();
                        if (got_sym !== want_sym) begin
                            n_miss++;
                            $display("FAIL sat_symbol%0d: got {bit,cnt,last}=%b want %b",
                                     seen, got_sym, want_sym);
                        end
                    end
                end
                if (bus3.in_valid && bus3.in_ready) idx++;
            end
            check_val("sat_bits_accepted", idx[15:0], 16'd16);
            check_val("sat_symbols_left", exp_q.size(), 16'd0);
            @(negedge clock);
            #1;
            check_val("sat_idle_busy", {15'b0, busy3}, 16'd0);
        end
`ifdef RLE_CTRL_STATS_EN
        check_val("stat_splits3", spl3, 16'd2);
        check_val("stat_symbols3", sym3, 16'd3);
        check_val("stat_symbols8", sym8, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/rle_encoder_ctrl.md
Name: rle_encoder_ctrl

Overview:
- Control FSM that sequences the RLE datapath: consumes a serial bit stream and emits (bit, run-length) symbols.
- Tracks the current run bit and run counter, and splits runs at counter saturation.
- Holds the first bit of the next run while the previous symbol drains.
- Valid/ready handshake on both sides; sits between the bit source and the RLE symbol packer.

Parameters:
- CNT_W, 8, run counter width; max run per symbol MAX = 2^CNT_W - 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_bit / in_last valid.
- in_ready  output  1  controller accepts input this cycle.
- in_bit  input  1  stream bit.
- in_last  input  1  final bit of the frame.
- out_valid  output  1  symbol valid.
- out_ready  input  1  downstream accepts symbol.
- out_bit  output  1  run bit value.
- out_count  output  CNT_W  run length, 1..MAX; 0 is never emitted.
- out_last  output  1  final symbol of the frame.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Registers: state, cur_bit, count, pend_valid, pend_bit, pend_last, last_flag.
- States: IDLE, RUN, EMIT.
- Reset (async, any state): state=IDLE and all registers 0. Outputs: in_ready=1, out_valid=0, out_bit=0, out_count=0, out_last=0, busy=0. Any pending symbol or bit is discarded.
- Handshakes: input accepted on in_valid&&in_ready; output on out_valid&&out_ready. out_* hold stable while out_valid=1 and out_ready=0.
- IDLE: in_ready=1, out_valid=0.
  - On accept: cur_bit<=in_bit, count<=1.
  - If in_last: last_flag<=1, go EMIT; else go RUN.
- RUN: in_ready=1, out_valid=0. On accept:
  - If in_bit==cur_bit and count<MAX: count<=count+1.
    - If in_last also set: last_flag<=1, go EMIT. Otherwise stay in RUN.
  - Else (bit change, or count==MAX): pend_valid<=1, pend_bit<=in_bit, pend_last<=in_last, go EMIT. The accepted bit is the first bit of the next run.
- EMIT: in_ready=0, out_valid=1, out_bit=cur_bit, out_count=count, out_last=last_flag && !pend_valid. On output accept:
  - If pend_valid: cur_bit<=pend_bit, count<=1, pend_valid<=0.
    - If pend_last: last_flag<=1, stay EMIT (single-bit final run). Otherwise go RUN.
  - Else (last_flag=1 necessarily): last_flag<=0, go IDLE.
- Latency: a symbol appears the cycle after the bit that terminates its run. Input stalls for exactly the cycles spent in EMIT.
- Saturation: a run of N equal bits is emitted as floor(N/MAX) symbols of MAX, plus one remainder symbol if N mod MAX != 0. Adjacent symbols may carry the same bit.
- in_last on the first bit of a frame yields one symbol with count=1 and out_last=1.
- Frames are back-to-back: IDLE accepts immediately after the last symbol handshake. No bubble is required beyond the EMIT cycle.
- in_bit / in_last are ignored when in_valid=0. out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: RLE_CTRL_STATS_EN.
- Defined:
  - Adds output stat_symbols [15:0]: increments on every output handshake and saturates at 16'hFFFF.
  - Adds output stat_splits [15:0]: increments when RUN forces a split because count==MAX; saturates.
  - Both counters cleared by reset only.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Reset mid-run: CNT_W=8, feed 1,1,1, then assert reset with out_ready=1 -> busy=0, out_valid=0, in_ready=1. After release, next frame "0 last" -> symbol (0,1,last=1).
- Basic frame: stream 1,1,1,0,0 (last on the final 0), out_ready=1 -> symbols (1,3,last=0) then (0,2,last=1), then IDLE.
- Single-bit frame: bit 1 with in_last, out_ready=1 -> one symbol (1,1,last=1).
- Final run of length 1: stream 0,0,1 (last on the 1) -> (0,2,0) then (1,1,1). in_ready stays 0 across both EMIT cycles.
- Saturation: CNT_W=3, 16 ones ending in last -> (1,7,0), (1,7,0), (1,2,1). With the macro defined, stat_splits=2 and stat_symbols=3.
- Backpressure: out_ready=0 for 5 cycles during EMIT of (1,3) -> out_bit/out_count/out_last held stable, in_ready=0, no input lost. Emission resumes when out_ready=1.
